// File: rtl/btb_arb_pkg.sv
// Shared types and default constants for the BTB update arbiter.
package btb_arb_pkg;

    localparam int unsigned DEFAULT_QUEUE_DEPTH  = 4;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 8;
    localparam int unsigned BTB_ADDR_W           = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE
    } btb_arb_state_t;

    // Queued entry width is fixed here, so the arbiter's ADDR_W must equal BTB_ADDR_W.
    typedef struct packed {
        logic [BTB_ADDR_W-1:0] pc;
        logic [BTB_ADDR_W-1:0] target;
    } btb_update_t;

endpackage

// File: rtl/btb_update_fifo.sv
// Update queue feeding the BTB write path.
// Defining BTB_UPDATE_COALESCE_EN merges an incoming update into a queued entry with the same PC.
module btb_update_fifo
    import btb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  btb_update_t push_data,
    input  logic        pop,
    input  logic        head_busy,
    output btb_update_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    btb_update_t      mem_q [DEPTH];
    btb_update_t      mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             coalesce;
    logic [PTR_W-1:0] hit_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

`ifdef BTB_UPDATE_COALESCE_EN
    logic [PTR_W-1:0] slot_off;

    // The head being written right now is excluded, so its in-flight value is not changed.
    always_comb begin
        coalesce = 1'b0;
        hit_idx  = '0;
        slot_off = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_off = PTR_W'(i) - rd_ptr_q;
            if (!coalesce && ({1'b0, slot_off} < count_q) &&
                (mem_q[i].pc == push_data.pc) &&
                !(head_busy && (PTR_W'(i) == rd_ptr_q))) begin
                coalesce = 1'b1;
                hit_idx  = PTR_W'(i);
            end
        end
    end
`else
    logic unused_head_busy;

    assign unused_head_busy = head_busy;
    assign coalesce         = 1'b0;
    assign hit_idx          = '0;
`endif

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            if (coalesce) begin
                mem_d[hit_idx].target = push_data.target;
            end else begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push && !coalesce) - CNT_W'(do_pop);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only read when count marks them valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/btb_update_arbiter.sv
// Shares the single BTB port between fetch lookups (priority) and queued branch updates.
// Defining BTB_UPDATE_COALESCE_EN merges queued updates that target the same PC.
module btb_update_arbiter
    import btb_arb_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH  = DEFAULT_QUEUE_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int unsigned ADDR_W       = BTB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_resp,
    output logic              if_hit,
    output logic [ADDR_W-1:0] if_target,
    input  logic              ex_update_valid,
    input  logic [ADDR_W-1:0] ex_update_pc,
    input  logic [ADDR_W-1:0] ex_update_target,
    output logic              ex_update_ready,
    output logic              btb_read,
    output logic              btb_write,
    output logic [ADDR_W-1:0] btb_addr,
    output logic [ADDR_W-1:0] btb_wdata,
    input  logic              btb_resp,
    input  logic              btb_hit,
    input  logic [ADDR_W-1:0] btb_rdata
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    btb_arb_state_t      state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    btb_update_t         fifo_in;
    btb_update_t         fifo_head;
    logic                lookup_ok;

    assign ex_update_ready = !fifo_full && !rst;
    assign fifo_push       = ex_update_valid && ex_update_ready;
    assign fifo_pop        = (state_q == UPDATE) && btb_resp && !rst;
    assign fifo_in         = '{pc: ex_update_pc, target: ex_update_target};
    assign lookup_ok       = fifo_empty || (starve_cnt_q < STARVE_W'(STARVE_LIMIT));

    btb_update_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .head_busy(state_q == UPDATE),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (if_read && lookup_ok) begin
                    state_d = LOOKUP;
                end else if (!fifo_empty) begin
                    state_d = UPDATE;
                end
            end
            LOOKUP: begin
                if (!if_read || btb_resp) begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                if (btb_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts only lookups granted over a waiting update; an update grant or empty queue clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || (state_q == IDLE && state_d == UPDATE)) begin
            starve_cnt_d = '0;
        end else if (state_q == IDLE && state_d == LOOKUP &&
                     starve_cnt_q < STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        btb_read  = 1'b0;
        btb_write = 1'b0;
        btb_addr  = '0;
        btb_wdata = '0;
        if_resp   = 1'b0;
        if_hit    = 1'b0;
        if_target = '0;
        if (!rst) begin
            case (state_q)
                LOOKUP: begin
                    btb_read = 1'b1;
                    btb_addr = if_pc;
                    if (if_read && btb_resp) begin
                        if_resp   = 1'b1;
                        if_hit    = btb_hit;
                        if_target = btb_rdata;
                    end
                end
                UPDATE: begin
                    btb_write = 1'b1;
                    btb_addr  = fifo_head.pc;
                    btb_wdata = fifo_head.target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Self-checking bench for btb_update_arbiter: vector table, corner sequences, random vs. queue model.
module tb_btb_update_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef logic [127:0] obs_t;

    typedef struct {
        logic        rst;
        logic        rd;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utg;
        logic        resp;
        logic        hit;
        logic [31:0] rdata;
        obs_t        exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } m_upd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_read;
    logic [31:0] if_pc;
    logic        if_resp;
    logic        if_hit;
    logic [31:0] if_target;
    logic        ex_update_valid;
    logic [31:0] ex_update_pc;
    logic [31:0] ex_update_target;
    logic        ex_update_ready;
    logic        btb_read;
    logic        btb_write;
    logic [31:0] btb_addr;
    logic [31:0] btb_wdata;
    logic        btb_resp;
    logic        btb_hit;
    logic [31:0] btb_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t        vecs[$];
    logic [31:0] wr_pc[$];
    logic [31:0] wr_tg[$];
    logic [31:0] ep[$];
    logic [31:0] et[$];

    m_upd_t mq[$];
    bit     m_lookup;
    bit     m_update;
    int     m_starve;

    always #5 clk = ~clk;

    btb_update_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .if_read         (if_read),
        .if_pc           (if_pc),
        .if_resp         (if_resp),
        .if_hit          (if_hit),
        .if_target       (if_target),
        .ex_update_valid (ex_update_valid),
        .ex_update_pc    (ex_update_pc),
        .ex_update_target(ex_update_target),
        .ex_update_ready (ex_update_ready),
        .btb_read        (btb_read),
        .btb_write       (btb_write),
        .btb_addr        (btb_addr),
        .btb_wdata       (btb_wdata),
        .btb_resp        (btb_resp),
        .btb_hit         (btb_hit),
        .btb_rdata       (btb_rdata)
    );

    function automatic obs_t eo(input logic ir, input logic ih, input logic [31:0] it,
                                input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic rdy);
        return {27'b0, ir, ih, it, r, w, a, wd, rdy};
    endfunction

    function automatic obs_t dut_obs();
        return eo(if_resp, if_hit, if_target, btb_read, btb_write, btb_addr, btb_wdata,
                  ex_update_ready);
    endfunction

    function automatic vec_t vv(input logic r, input logic rd, input logic [31:0] pc,
                                input logic uv, input logic [31:0] upc, input logic [31:0] utg,
                                input logic resp, input logic hit, input logic [31:0] rdata,
                                input obs_t exp);
        vec_t v;
        v = '{rst: r, rd: rd, pc: pc, uv: uv, upc: upc, utg: utg,
              resp: resp, hit: hit, rdata: rdata, exp: exp};
        return v;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_read          = 1'b0;
        if_pc            = '0;
        ex_update_valid  = 1'b0;
        ex_update_pc     = '0;
        ex_update_target = '0;
        btb_resp         = 1'b0;
        btb_hit          = 1'b0;
        btb_rdata        = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next();
        rst = 1'b0;
    endtask

    task automatic drain_collect(input int cycles);
        if_read         = 1'b0;
        ex_update_valid = 1'b0;
        btb_resp        = 1'b1;
        wr_pc.delete();
        wr_tg.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (btb_write) begin
                wr_pc.push_back(btb_addr);
                wr_tg.push_back(btb_wdata);
            end
            next();
        end
    endtask

    task automatic check_writes(input string name);
        check_int({name, "_count"}, wr_pc.size(), ep.size());
        for (int i = 0; i < ep.size() && i < wr_pc.size(); i++) begin
            check($sformatf("%s_pc%0d", name, i), obs_t'(wr_pc[i]), obs_t'(ep[i]));
            check($sformatf("%s_tg%0d", name, i), obs_t'(wr_tg[i]), obs_t'(et[i]));
        end
    endtask

    // Reference: port owner flags, an SV queue of pending updates, and a lookup-streak counter.
    function automatic obs_t model_obs();
        logic        ir;
        logic [31:0] a;
        logic [31:0] wd;
        if (rst) return '0;
        ir = m_lookup && if_read && btb_resp;
        a  = m_lookup ? if_pc : (m_update ? mq[0].pc : 32'h0);
        wd = m_update ? mq[0].target : 32'h0;
        return eo(ir, ir && btb_hit, ir ? btb_rdata : 32'h0, m_lookup, m_update, a, wd,
                  mq.size() < DEPTH);
    endfunction

    task automatic model_step();
        int sz;
        bit was_update;
        bit merged;
        sz         = mq.size();
        was_update = m_update;
        merged     = 1'b0;
        if (rst) begin
            mq.delete();
            m_lookup = 1'b0;
            m_update = 1'b0;
            m_starve = 0;
            return;
        end
        if (m_lookup) begin
            if (!if_read || btb_resp) m_lookup = 1'b0;
        end else if (m_update) begin
            if (btb_resp) m_update = 1'b0;
        end else if (if_read && (sz == 0 || m_starve < LIMIT)) begin
            m_lookup = 1'b1;
            if (sz > 0) m_starve++;
        end else if (sz > 0) begin
            m_update = 1'b1;
            m_starve = 0;
        end
        if (sz == 0) m_starve = 0;
        if (ex_update_valid && sz < DEPTH) begin
`ifdef BTB_UPDATE_COALESCE_EN
            for (int i = 0; i < sz; i++) begin
                if (!merged && !(was_update && i == 0) && mq[i].pc == ex_update_pc) begin
                    mq[i].target = ex_update_target;
                    merged       = 1'b1;
                end
            end
`endif
            if (!merged) mq.push_back('{pc: ex_update_pc, target: ex_update_target});
        end
        if (was_update && btb_resp) void'(mq.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lookups;
        int          lookups_after;
        int          writes_seen;
        logic [31:0] starve_wr_addr;
        bit          seen;
        bit          prev_resp;
        obs_t        exp;

        rst = 1'b1;
        clear_inputs();
        next();

        // Vector table: rst, rd, pc, uv, upc, utg, resp, hit, rdata, expected outputs
        vecs.push_back(vv(1, 0, 0,      0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      0)));
        vecs.push_back(vv(0, 1, 'h60,   0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));
        vecs.push_back(vv(0, 1, 'h60,   0, 0,      0,      1, 1, 'h80,   eo(1, 1, 'h80,   1, 0, 'h60,   0,      1)));
        vecs.push_back(vv(0, 0, 0,      1, 'h100,  'h200,  0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));
        vecs.push_back(vv(0, 0, 0,      0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));
        vecs.push_back(vv(0, 0, 0,      0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 1, 'h100,  'h200,  1)));
        vecs.push_back(vv(0, 0, 0,      0, 0,      0,      1, 0, 0,      eo(0, 0, 0,      0, 1, 'h100,  'h200,  1)));
        vecs.push_back(vv(0, 1, 'h64,   0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));
        vecs.push_back(vv(0, 0, 'h64,   0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      1, 0, 'h64,   0,      1)));
        vecs.push_back(vv(0, 1, 'h70,   0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));
        vecs.push_back(vv(0, 1, 'h70,   0, 0,      0,      1, 0, 'h1234, eo(1, 0, 'h1234, 1, 0, 'h70,   0,      1)));
        vecs.push_back(vv(0, 0, 0,      1, 'h300,  'h400,  0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));
        vecs.push_back(vv(0, 1, 'h88,   0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));
        vecs.push_back(vv(0, 1, 'h88,   0, 0,      0,      1, 1, 'h90,   eo(1, 1, 'h90,   1, 0, 'h88,   0,      1)));
        vecs.push_back(vv(0, 0, 0,      0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));
        vecs.push_back(vv(0, 0, 0,      0, 0,      0,      1, 0, 0,      eo(0, 0, 0,      0, 1, 'h300,  'h400,  1)));
        vecs.push_back(vv(0, 0, 0,      0, 0,      0,      0, 0, 0,      eo(0, 0, 0,      0, 0, 0,      0,      1)));

        for (int i = 0; i < vecs.size(); i++) begin
            rst              = vecs[i].rst;
            if_read          = vecs[i].rd;
            if_pc            = vecs[i].pc;
            ex_update_valid  = vecs[i].uv;
            ex_update_pc     = vecs[i].upc;
            ex_update_target = vecs[i].utg;
            btb_resp         = vecs[i].resp;
            btb_hit          = vecs[i].hit;
            btb_rdata        = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_obs(), vecs[i].exp);
            next();
        end

        // Fill: four updates while a lookup holds the port, fifth refused
        do_reset();
        if_read = 1'b1;
        if_pc   = 32'h500;
        next();
        for (int k = 0; k < 4; k++) begin
            ex_update_valid  = 1'b1;
            ex_update_pc     = 32'h10 + 32'(k);
            ex_update_target = 32'hA0 + 32'(k);
            @(negedge clk);
            if (k == 3) check_int("fill_ready_before_4th", int'(ex_update_ready), 1);
            next();
        end
        ex_update_pc     = 32'h14;
        ex_update_target = 32'hA4;
        @(negedge clk);
        check_int("fill_full_ready", int'(ex_update_ready), 0);
        next();
        if_read = 1'b0;
        @(negedge clk);
        check_int("fill_still_full", int'(ex_update_ready), 0);
        next();
        ex_update_valid = 1'b0;
        next();
        btb_resp = 1'b1;
        @(negedge clk);
        check("fill_first_pop", dut_obs(), eo(0, 0, 0, 0, 1, 32'h10, 32'hA0, 0));
        next();
        @(negedge clk);
        check_int("fill_ready_after_pop", int'(ex_update_ready), 1);
        drain_collect(12);
        ep = '{32'h11, 32'h12, 32'h13};
        et = '{32'hA1, 32'hA2, 32'hA3};
        check_writes("fill_drain");

        // Starvation: one queued update against a continuous lookup stream
        do_reset();
        ex_update_valid  = 1'b1;
        ex_update_pc     = 32'h700;
        ex_update_target = 32'h777;
        next();
        ex_update_valid = 1'b0;
        if_read         = 1'b1;
        if_pc           = 32'h1000;
        btb_resp        = 1'b1;
        btb_hit         = 1'b1;
        btb_rdata       = 32'h2000;
        lookups         = 0;
        lookups_after   = 0;
        writes_seen     = 0;
        starve_wr_addr  = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (btb_read) begin
                if (writes_seen == 0) lookups++;
                else lookups_after++;
            end
            if (btb_write) begin
                writes_seen++;
                starve_wr_addr = btb_addr;
            end
            next();
        end
        check_int("starve_lookups_before_update", lookups, LIMIT);
        check_int("starve_single_update", writes_seen, 1);
        check("starve_update_addr", obs_t'(starve_wr_addr), obs_t'(32'h700));
        check_int("starve_lookups_resume", int'(lookups_after > 0), 1);

        // Reset while an update holds the port
        do_reset();
        ex_update_valid  = 1'b1;
        ex_update_pc     = 32'h900;
        ex_update_target = 32'h901;
        next();
        ex_update_pc     = 32'h910;
        ex_update_target = 32'h911;
        next();
        ex_update_valid = 1'b0;
        seen            = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = btb_write;
            next();
        end
        check_int("rst_upd_write_seen", int'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_upd_during", dut_obs(), '0);
        next();
        rst = 1'b0;
        @(negedge clk);
        check("rst_upd_after", dut_obs(), eo(0, 0, 0, 0, 0, 0, 0, 1));
        next();
        drain_collect(8);
        ep.delete();
        et.delete();
        check_writes("rst_upd_drain");

        // Same-PC updates queued while the port is busy
        do_reset();
        if_read = 1'b1;
        if_pc   = 32'h3000;
        next();
        ex_update_valid  = 1'b1;
        ex_update_pc     = 32'h40;
        ex_update_target = 32'h1;
        next();
        ex_update_target = 32'h2;
        next();
        ex_update_valid = 1'b0;
        if_read         = 1'b0;
        next();
        drain_collect(10);
`ifdef BTB_UPDATE_COALESCE_EN
        ep = '{32'h40};
        et = '{32'h2};
`else
        ep = '{32'h40, 32'h40};
        et = '{32'h1, 32'h2};
`endif
        check_writes("coalesce");

        // Random traffic against the queue model
        do_reset();
        mq.delete();
        m_lookup  = 1'b0;
        m_update  = 1'b0;
        m_starve  = 0;
        prev_resp = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (rst || prev_resp) if_read = 1'b0;
            rst = ($urandom_range(0, 127) == 0);
            if (!if_read) begin
                if ($urandom_range(0, 1) == 1) begin
                    if_read = 1'b1;
                    if_pc   = 32'($urandom_range(0, 63)) << 2;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if_read = 1'b0;
            end
            btb_resp         = 1'($urandom_range(0, 1));
            btb_hit          = 1'($urandom_range(0, 1));
            btb_rdata        = $urandom;
            ex_update_valid  = ($urandom_range(0, 2) == 0);
            ex_update_pc     = 32'h40 + (32'($urandom_range(0, 3)) << 2);
            ex_update_target = $urandom;
            exp              = model_obs();
            prev_resp        = exp[100];
            @(negedge clk);
            check($sformatf("rand%0d", c), dut_obs(), exp);
            model_step();
            next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
